rsa_exp_scheduler: RTL

Shares a single `modular_exp` engine between two independent requesters, such as the encrypt and decrypt front-ends. The block does four things:
- arbitrates round-robin between the two requesters;
- latches operands and sequences the engine's start/ready handshake;
- returns each result tagged with the requester id on a back-pressured response channel;
- rejects a zero modulus and recovers from a hung engine with a watchdog.

It sits between the request front-ends and the engine; the engine is instantiated alongside it, not inside it.

---
 rtl/rsa_pkg.sv | 20 ++
 rtl/rsa_exp_scheduler_if.sv | 43 ++++
 rtl/rsa_rr_arb2.sv | 23 ++
 rtl/rsa_exp_scheduler.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the modular-exponentiation scheduler.
// Holds the default operand width, the requester id type and the
// scheduler state encoding used by the top-level FSM.
package rsa_pkg;

  localparam int RSA_WIDTH = 256;
  localparam int ID_W      = 1;

  typedef logic [ID_W-1:0] req_id_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ARM   = 3'd2,
    S_BUSY  = 3'd3,
    S_RESP  = 3'd4,
    S_DRAIN = 3'd5
  } state_e;

endpackage

// File: rtl/rsa_exp_scheduler_if.sv
// Bundle of the scheduler's request, response and engine-side signals.
//   req_*_0 / req_*_1 : two requester channels (valid/ready + operands)
//   rsp_*             : tagged, back-pressured result channel
//   me_*              : start/ready handshake and operands of the shared engine
// Modports: slave = the scheduler, master = everything around it.
interface rsa_exp_scheduler_if #(
  parameter int WIDTH = rsa_pkg::RSA_WIDTH
);
  import rsa_pkg::*;

  logic             req_valid_0, req_ready_0;
  logic             req_valid_1, req_ready_1;
  logic [WIDTH-1:0] req_base_0, req_exp_0, req_n_0;
  logic [WIDTH-1:0] req_base_1, req_exp_1, req_n_1;

  logic             rsp_valid, rsp_ready, rsp_err;
  req_id_t          rsp_id;
  logic [WIDTH-1:0] rsp_data;

  logic             me_start, me_ready;
  logic [WIDTH-1:0] me_base, me_exp, me_n, me_result;

  modport slave (
    input  req_valid_0, req_base_0, req_exp_0, req_n_0,
    input  req_valid_1, req_base_1, req_exp_1, req_n_1,
    output req_ready_0, req_ready_1,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    input  rsp_ready,
    output me_start, me_base, me_exp, me_n,
    input  me_result, me_ready
  );

  modport master (
    output req_valid_0, req_base_0, req_exp_0, req_n_0,
    output req_valid_1, req_base_1, req_exp_1, req_n_1,
    input  req_ready_0, req_ready_1,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    output rsp_ready,
    input  me_start, me_base, me_exp, me_n,
    output me_result, me_ready
  );

endinterface

// File: rtl/rsa_rr_arb2.sv
// Two-way round-robin arbiter.
//   valid[1:0] : request flags
//   last       : id granted most recently
//   grant      : winning id (meaningful only when grant_vld)
//   grant_vld  : at least one request present
// A lone requester always wins; on a tie the one opposite to last wins.
module rsa_rr_arb2
  import rsa_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last,
  output req_id_t    grant,
  output logic       grant_vld
);

  always_comb begin
    grant_vld = |valid;
    grant     = '0;
    if (valid == 2'b11) grant = ~last;
    else if (valid[1])  grant = 1'b1;
  end

endmodule

// File: rtl/rsa_exp_scheduler.sv
// Shares one modular-exponentiation engine between two requesters.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : request/response/engine signals (slave modport)
//   busy       : high whenever the FSM is outside IDLE
// Jobs are granted round-robin, operands are latched into me_*, the
// engine is started with a one-cycle pulse and its result is returned
// tagged with the requester id. A zero modulus is rejected without
// touching the engine; a watchdog aborts a hung engine and the FSM
// then drains until the engine reports idle again.
module rsa_exp_scheduler
  import rsa_pkg::*;
#(
  parameter int WIDTH   = RSA_WIDTH,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  rsa_exp_scheduler_if.slave bus,
  output logic              busy
);

  localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT);
  localparam bit          WD_EN    = (TIMEOUT != 0);

  state_e           state_q, state_d;
  req_id_t          last_q, last_d, id_q, id_d, grant;
  logic             grant_vld, accept, wd_fire;
  logic [WIDTH-1:0] base_q, base_d, exp_q, exp_d, n_q, n_d, data_q, data_d;
  logic [WIDTH-1:0] sel_base, sel_exp, sel_n;
  logic             start_q, start_d, valid_q, valid_d, err_q, err_d;
  logic             to_q, to_d, busy_q, busy_d;
  logic [31:0]      cnt_q, cnt_d;

  rsa_rr_arb2 u_arb (
    .valid     ({bus.req_valid_1, bus.req_valid_0}),
    .last      (last_q),
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  // The arbiter only grants a valid requester, so accept is the handshake.
  assign accept   = (state_q == S_IDLE) && bus.me_ready && grant_vld;
  assign sel_base = grant[0] ? bus.req_base_1 : bus.req_base_0;
  assign sel_exp  = grant[0] ? bus.req_exp_1  : bus.req_exp_0;
  assign sel_n    = grant[0] ? bus.req_n_1    : bus.req_n_0;
  // Counter reads k in the k-th cycle after ARM entry; fire as it would reach the limit.
  assign wd_fire  = WD_EN && ((cnt_q + 32'd1) >= WD_LIMIT);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    base_d  = base_q;
    exp_d   = exp_q;
    n_d     = n_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          base_d = sel_base;
          exp_d  = sel_exp;
          n_d    = sel_n;
          id_d   = grant;
          last_d = grant;
          if (sel_n == '0) begin
            valid_d = 1'b1;
            err_d   = 1'b1;
            data_d  = '0;
            to_d    = 1'b0;
            state_d = S_RESP;
          end else begin
            start_d = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_ARM;
      end
      S_ARM: begin
        cnt_d = cnt_q + 32'd1;
        if (wd_fire) begin
          valid_d = 1'b1;
          err_d   = 1'b1;
          data_d  = '0;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else if (!bus.me_ready) begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 32'd1;
        // A result arriving in the same cycle as the timeout still wins.
        if (bus.me_ready) begin
          valid_d = 1'b1;
          err_d   = 1'b0;
          data_d  = bus.me_result;
          to_d    = 1'b0;
          state_d = S_RESP;
        end else if (wd_fire) begin
          valid_d = 1'b1;
          err_d   = 1'b1;
          data_d  = '0;
          to_d    = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          valid_d = 1'b0;
          state_d = to_q ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (bus.me_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      id_q    <= '0;
      base_q  <= '0;
      exp_q   <= '0;
      n_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      n_q     <= n_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  // Gate with rst_n so the ready outputs read 0 while reset is held.
  assign bus.req_ready_0 = rst_n && accept && (grant == 1'b0);
  assign bus.req_ready_1 = rst_n && accept && (grant == 1'b1);
  assign bus.rsp_valid   = valid_q;
  assign bus.rsp_id      = id_q;
  assign bus.rsp_data    = data_q;
  assign bus.rsp_err     = err_q;
  assign bus.me_start    = start_q;
  assign bus.me_base     = base_q;
  assign bus.me_exp      = exp_q;
  assign bus.me_n        = n_q;
  assign busy            = busy_q;

endmodule
